// File: rtl/wb_pkg.sv
// Shared types for the register writeback block.
// Register index, data word, load-buffer entry and defaults.
package wb_pkg;

   localparam int XLEN_DEFAULT         = 32;
   localparam int LOAD_Q_DEPTH_DEFAULT = 2;

   typedef logic [4:0]              reg_idx_t;
   typedef logic [XLEN_DEFAULT-1:0] xlen_t;

   typedef struct packed {
      reg_idx_t rd;
      xlen_t    val;
   } wb_entry_t;

   localparam reg_idx_t REG_X0 = 5'd0;

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO buffering load results that lose write-port arbitration.
// Ports: clk, reset (sync, active-high), i_push/i_data, i_pop, o_full, o_empty, o_head.
module wb_load_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = LOAD_Q_DEPTH_DEFAULT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      i_push,
   input  wb_entry_t i_data,
   input  logic      i_pop,
   output logic      o_full,
   output logic      o_empty,
   output wb_entry_t o_head
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t       r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port producer: ALU results win, buffered loads fill gaps;
// pending-load scoreboard feeds decode RAW stalls. Ports: clk, reset (sync, high),
// issue_*, alu_*, ld_* (valid/ready), query_rs1/2 -> rs1/2_busy, write_*, wb_err.
// Optional macro REG_WRITEBACK_CHECK_EN enables sticky protocol checking on wb_err.
module reg_writeback
   import wb_pkg::*;
#(
   parameter int LOAD_Q_DEPTH = LOAD_Q_DEPTH_DEFAULT,
   parameter int XLEN         = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic            issue_is_load,
   input  logic [4:0]      issue_rd,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_val,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_val,
   input  logic [4:0]      query_rs1,
   input  logic [4:0]      query_rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            write_en_rd,
   output logic [4:0]      write_rd,
   output logic [XLEN-1:0] write_val,
   output logic            wb_err
);

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_set;
   wb_entry_t   w_in;
   wb_entry_t   w_head;
   logic [31:0] r_pending;
   logic [31:0] w_pend_nxt;

   assign ld_ready = !reset && !w_full;
   assign w_push   = ld_valid && ld_ready;
   assign w_in.rd  = ld_rd;
   assign w_in.val = xlen_t'(ld_val);

   // The buffer drains only in cycles the ALU leaves the port idle.
   assign w_pop = !reset && !alu_valid && !w_empty;
   assign w_set = issue_valid && issue_is_load && (issue_rd != REG_X0);

   wb_load_fifo #(
      .DEPTH (LOAD_Q_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_in),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_comb begin
      write_en_rd = 1'b0;
      write_rd    = '0;
      write_val   = '0;
      if (!reset && alu_valid) begin
         write_en_rd = (alu_rd != REG_X0);
         write_rd    = alu_rd;
         write_val   = alu_val;
      end else if (w_pop) begin
         write_en_rd = (w_head.rd != REG_X0);
         write_rd    = w_head.rd;
         write_val   = XLEN'(w_head.val);
      end
   end

   // Set after clear so a new load to the same rd stays outstanding.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_pop) w_pend_nxt[w_head.rd] = 1'b0;
      if (w_set) w_pend_nxt[issue_rd]  = 1'b1;
      w_pend_nxt[REG_X0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) r_pending <= '0;
      else       r_pending <= w_pend_nxt;
   end

   // The register file bypass supplies the value in the popping cycle.
   assign rs1_busy = !reset && (query_rs1 != REG_X0) &&
                     r_pending[query_rs1] &&
                     !(w_pop && (w_head.rd == query_rs1));
   assign rs2_busy = !reset && (query_rs2 != REG_X0) &&
                     r_pending[query_rs2] &&
                     !(w_pop && (w_head.rd == query_rs2));

`ifdef REG_WRITEBACK_CHECK_EN
   logic w_alu_bad;
   logic w_ld_bad;
   logic r_err;

   assign w_alu_bad = alu_valid && (alu_rd != REG_X0) && r_pending[alu_rd];
   assign w_ld_bad  = w_push && (ld_rd != REG_X0) && !r_pending[ld_rd];

   always_ff @(posedge clk) begin
      if (reset)                      r_err <= ld_valid;
      else if (w_alu_bad || w_ld_bad) r_err <= 1'b1;
   end

   assign wb_err = r_err;
`else
   assign wb_err = 1'b0;
`endif

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Producer side of the register-file write port. Merges single-cycle ALU results and variable-latency load results into the single `write_en_rd`/`write_rd`/`write_val` port.
- Buffers load results that lose arbitration.
- Keeps a pending-load scoreboard so decode can stall on RAW hazards against outstanding loads.
- Sits between the execute/load units and the register file.

Parameters:
- LOAD_Q_DEPTH, 2, number of load-result buffer entries (power of two, ≥2)
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode issues an instruction this cycle
- issue_is_load  in  1  the issued instruction is a load
- issue_rd  in  5  destination of the issued instruction
- alu_valid  in  1  ALU result present (never back-pressured)
- alu_rd  in  5  ALU destination
- alu_val  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  buffer can accept a load result
- ld_rd  in  5  load destination
- ld_val  in  XLEN  load data
- query_rs1  in  5  decode source 1
- query_rs2  in  5  decode source 2
- rs1_busy  out  1  rs1 has an outstanding load
- rs2_busy  out  1  rs2 has an outstanding load
- write_en_rd  out  1  register-file write enable
- write_rd  out  5  register-file write index
- write_val  out  XLEN  register-file write data
- wb_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset effects:
  - Load buffer emptied; scoreboard cleared; `wb_err` cleared.
  - `ld_ready`=0, `write_en_rd`=0, `rs1_busy`=`rs2_busy`=0 during the reset cycle.
  - Reset mid-operation discards buffered and in-flight load results without writing.
- Load handshake: a transfer occurs when `ld_valid && ld_ready`. `ld_ready` = buffer not full (registered count; no same-cycle pop-to-push pass-through).
- Write-port arbitration, combinational, zero latency:
  - `alu_valid` has priority: `write_rd`=`alu_rd`, `write_val`=`alu_val`.
  - Otherwise, if the buffer is non-empty, the head entry is popped: `write_rd`/`write_val` come from the head.
  - Otherwise `write_en_rd`=0, and `write_rd`/`write_val` are 0.
- Load path latency: an accepted load is written no earlier than the cycle after acceptance (it always passes through the buffer). Buffer order is FIFO.
- x0 handling: `write_en_rd` = selected source valid && selected rd≠0. A head entry with rd=0 is still popped, but not written.
- Scoreboard, 31 pending bits (x1..x31):
  - Set at the clock edge when `issue_valid && issue_is_load && issue_rd≠0`.
  - Cleared when a head entry with that rd is popped.
  - Simultaneous set and clear of the same rd: set wins (a new load is outstanding).
- Busy outputs: `rsN_busy` = pending[query_rsN] && !(buffer pop this cycle with head rd == query_rsN); always 0 for x0. The register file's write bypass supplies the value in the popping cycle.
- Full buffer: `ld_ready`=0 until a pop occurs. Sustained `alu_valid` starves the buffer; decode back-pressure is responsible for bounding this.
- Ordering guarantee: decode never issues two loads with the same rd while one is outstanding (it stalls on busy). An ALU write to a pending rd is a decode bug.

Optional Feature:
- Macro: `REG_WRITEBACK_CHECK_EN`.
- When defined, `wb_err` is set sticky (cleared only by reset) on any of:
  - `alu_valid` with `alu_rd`≠0 while pending[`alu_rd`]
  - accepted load whose rd≠0 is not pending
  - `ld_valid` asserted during the reset cycle
- When undefined, `wb_err` is tied 0 and no check logic is generated.

Decomposition:
- Shared package `wb_pkg`:
  - `reg_idx_t` (5 bits)
  - `xlen_t`
  - `wb_entry_t` struct {rd, val}
  - `LOAD_Q_DEPTH_DEFAULT`
  - constant `REG_X0`=0
- Sub-module `wb_load_fifo`: synchronous FIFO of `wb_entry_t`, with push/pop/full/empty/head.
- The scoreboard and arbitration stay in `reg_writeback`.

Test Plan:
- Reset, then `alu_valid` with rd=5, val=0x1234 -> same-cycle `write_en_rd`=1, `write_rd`=5, `write_val`=0x1234; `ld_ready`=1.
- Issue load rd=7, then one cycle later `ld_valid` with rd=7, val=0xDEADBEEF -> `rs1_busy`=1 for query 7 until the pop; write occurs the next cycle; busy drops in the pop cycle; pending bit clear afterwards.
- `alu_valid` held 3 cycles while 2 loads (rd=8, rd=9) arrive -> `ld_ready`=0 after 2 pushes; both loads written in order 8 then 9 once ALU idles.
- Load to rd=0 accepted -> popped with `write_en_rd`=0; issue load rd=0 -> `rs1_busy`=0 for query 0.
- Same cycle: pop of rd=10 and issue of a new load rd=10 -> pending[10] remains 1.
- `REG_WRITEBACK_CHECK_EN` build: ALU write rd=12 while load rd=12 is pending -> `wb_err`=1 next cycle and stays set until reset; non-macro build: `wb_err`=0.
